// File: rtl/microwave_cook_ctrl.sv
// microwave_cook_ctrl: keypad time entry, BCD M:SS countdown, power-level
// duty cycling of the magnetron, pause/resume and a timed completion beep.
// Every output is a register; the next-state logic is one combinational block.

module microwave_cook_ctrl #(
   parameter int TICKS_PER_SEC = 100,
   parameter int BEEP_SECS     = 3
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       power_key,
   input  logic       start,
   input  logic       stop,
   input  logic       door_closed,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] mins,
   output logic [3:0] power_level,
   output logic       mag_on,
   output logic       running,
   output logic       done_beep
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_SEC - 1);
   localparam logic [BW-1:0] BEEP_MAX = BW'(BEEP_SECS - 1);

   typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

   state_t          state, state_n;
   logic [PW-1:0]   prescaler, prescaler_n, pre_inc;
   logic [3:0]      phase, phase_n, phase_inc;
   logic [BW-1:0]   beep_cnt, beep_cnt_n;
   logic [3:0]      ones_n, tens_n, mins_n, power_n, power_dec;
   logic [3:0]      dec_ones, dec_tens, dec_mins;
   logic            tick, dec_zero, time_zero, start_ok, digit_ok;
   logic            mag_on_n, running_n, done_beep_n;

   // Shared helpers: the second tick, BCD decrement of M:SS, phase and power
   // stepping, and the conditions under which a start is accepted.
   always_comb begin
      tick      = (prescaler == PRE_MAX);
      pre_inc   = tick ? '0 : prescaler + 1'b1;
      phase_inc = (phase == 4'd9) ? 4'd0 : phase + 4'd1;
      power_dec = (power_level == 4'd1) ? 4'd10 : power_level - 4'd1;
      dec_ones  = sec_ones;
      dec_tens  = sec_tens;
      dec_mins  = mins;
      if (sec_ones != 4'd0) begin
         dec_ones = sec_ones - 4'd1;
      end else if (sec_tens != 4'd0) begin
         dec_ones = 4'd9;
         dec_tens = sec_tens - 4'd1;
      end else if (mins != 4'd0) begin
         dec_ones = 4'd9;
         dec_tens = 4'd5;
         dec_mins = mins - 4'd1;
      end
      dec_zero  = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_mins == 4'd0);
      time_zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (mins == 4'd0);
      start_ok  = door_closed && !time_zero && (sec_tens <= 4'd5);
      digit_ok  = key_valid && (key_digit <= 4'd9);
   end

   // Next-state and next-output computation; outputs are derived from the
   // next state so that they appear on the same edge as the state change.
   always_comb begin
      state_n     = state;
      prescaler_n = prescaler;
      phase_n     = phase;
      beep_cnt_n  = beep_cnt;
      ones_n      = sec_ones;
      tens_n      = sec_tens;
      mins_n      = mins;
      power_n     = power_level;
      case (state)
         IDLE: begin
            if (stop) begin
               ones_n  = 4'd0;
               tens_n  = 4'd0;
               mins_n  = 4'd0;
               power_n = 4'd10;
            end else if (start && start_ok) begin
               state_n     = COOK;
               prescaler_n = '0;
               phase_n     = 4'd0;
            end else begin
               if (digit_ok) begin
                  mins_n = sec_tens;
                  tens_n = sec_ones;
                  ones_n = key_digit;
               end
               if (power_key) begin
                  power_n = power_dec;
               end
            end
         end
         COOK: begin
            prescaler_n = pre_inc;
            if (tick) begin
               ones_n  = dec_ones;
               tens_n  = dec_tens;
               mins_n  = dec_mins;
               phase_n = phase_inc;
            end
            if (tick && dec_zero) begin
               state_n    = DONE;
               beep_cnt_n = '0;
            end else if (stop || !door_closed) begin
               state_n = PAUSE;
            end
         end
         PAUSE: begin
            if (stop) begin
               state_n = IDLE;
               ones_n  = 4'd0;
               tens_n  = 4'd0;
               mins_n  = 4'd0;
            end else if (start && door_closed) begin
               state_n     = COOK;
               prescaler_n = '0;
            end
         end
         DONE: begin
            prescaler_n = pre_inc;
            if (stop || key_valid) begin
               state_n    = IDLE;
               power_n    = 4'd10;
               beep_cnt_n = '0;
            end else if (tick) begin
               if (beep_cnt == BEEP_MAX) begin
                  state_n    = IDLE;
                  power_n    = 4'd10;
                  beep_cnt_n = '0;
               end else begin
                  beep_cnt_n = beep_cnt + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      running_n   = (state_n == COOK);
      done_beep_n = (state_n == DONE);
      mag_on_n    = (state_n == COOK) && door_closed && (phase_n < power_n);
   end

   // State and output registers with synchronous clear.
   always_ff @(posedge clock) begin
      if (clear) begin
         state       <= IDLE;
         prescaler   <= '0;
         phase       <= 4'd0;
         beep_cnt    <= '0;
         sec_ones    <= 4'd0;
         sec_tens    <= 4'd0;
         mins        <= 4'd0;
         power_level <= 4'd10;
         mag_on      <= 1'b0;
         running     <= 1'b0;
         done_beep   <= 1'b0;
      end else begin
         state       <= state_n;
         prescaler   <= prescaler_n;
         phase       <= phase_n;
         beep_cnt    <= beep_cnt_n;
         sec_ones    <= ones_n;
         sec_tens    <= tens_n;
         mins        <= mins_n;
         power_level <= power_n;
         mag_on      <= mag_on_n;
         running     <= running_n;
         done_beep   <= done_beep_n;
      end
   end

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Directed testbench for microwave_cook_ctrl with 4 ticks per second and a
// 3-second beep; expected values are worked out by hand for each step.

module tb_microwave_cook_ctrl;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_digit = 4'd0;
   logic       power_key = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       door_closed = 1'b1;
   logic [3:0] sec_ones, sec_tens, mins, power_level;
   logic       mag_on, running, done_beep;

   int checks = 0;
   int errors = 0;

   microwave_cook_ctrl #(.TICKS_PER_SEC(4), .BEEP_SECS(3)) dut (
      .clock(clock), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
      .power_key(power_key), .start(start), .stop(stop), .door_closed(door_closed),
      .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins), .power_level(power_level),
      .mag_on(mag_on), .running(running), .done_beep(done_beep)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Advance n rising edges and settle 1 time unit after the last one.
   task automatic cycle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Drive one cycle of strobes, then release them.
   task automatic applyStimulus(input logic kv, input logic [3:0] kd, input logic pk,
                                input logic st, input logic sp);
      key_valid = kv; key_digit = kd; power_key = pk; start = st; stop = sp;
      cycle(1);
      key_valid = 1'b0; key_digit = 4'd0; power_key = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkTime(input string tag, input logic [11:0] exp);
      checkOutput(tag, {4'd0, mins, sec_tens, sec_ones}, {4'd0, exp});
   endtask

   initial begin
      int cookCycles, onCycles, beepCycles, guard;

      // Reset
      cycle(2);
      clear = 1'b0;
      checkTime("reset_time", 12'h000);
      checkOutput("reset_power", 16'(power_level), 16'd10);
      checkOutput("reset_flags", 16'({mag_on, running, done_beep}), 16'd0);

      // Entry and short cook
      $display("[TB] entry and short cook");
      applyStimulus(1, 4'd1, 0, 0, 0);
      applyStimulus(1, 4'd3, 0, 0, 0);
      applyStimulus(1, 4'd0, 0, 0, 0);
      checkTime("entry_130", 12'h130);
      applyStimulus(0, 4'd0, 0, 1, 0);
      checkOutput("cook_running", 16'(running), 16'd1);
      checkOutput("cook_mag_on", 16'(mag_on), 16'd1);
      cycle(3);
      checkTime("before_first_tick", 12'h130);
      cycle(1);
      checkTime("first_tick_129", 12'h129);
      cycle(116);
      checkTime("reach_100", 12'h100);
      cycle(4);
      checkTime("borrow_059", 12'h059);
      applyStimulus(0, 4'd0, 0, 0, 1);
      checkOutput("stop_pauses", 16'(running), 16'd0);
      checkTime("pause_holds", 12'h059);
      applyStimulus(0, 4'd0, 0, 0, 1);
      checkTime("pause_stop_zero", 12'h000);

      // Power duty and completion
      $display("[TB] power duty and completion");
      repeat (7) applyStimulus(0, 4'd0, 1, 0, 0);
      checkOutput("power_3", 16'(power_level), 16'd3);
      applyStimulus(1, 4'd2, 0, 0, 0);
      applyStimulus(1, 4'd0, 0, 0, 0);
      applyStimulus(0, 4'd0, 0, 1, 0);
      cookCycles = 0; onCycles = 0; guard = 0;
      while (running && guard < 1000) begin
         cookCycles++;
         if (mag_on) onCycles++;
         guard++;
         cycle(1);
      end
      checkOutput("cook_loop_bound", 16'(guard < 1000), 16'd1);
      checkOutput("cook_cycles_20s", 16'(cookCycles), 16'd80);
      checkOutput("mag_on_cycles", 16'(onCycles), 16'd24);
      checkOutput("done_beep_high", 16'(done_beep), 16'd1);
      checkOutput("done_mag_off", 16'(mag_on), 16'd0);
      checkTime("done_time", 12'h000);
      beepCycles = 0; guard = 0;
      while (done_beep && guard < 1000) begin
         beepCycles++;
         guard++;
         cycle(1);
      end
      checkOutput("beep_cycles", 16'(beepCycles), 16'd12);
      checkOutput("done_power_reset", 16'(power_level), 16'd10);

      // Pause and resume with phase preserved
      $display("[TB] pause and resume");
      repeat (5) applyStimulus(0, 4'd0, 1, 0, 0);
      applyStimulus(1, 4'd5, 0, 0, 0);
      applyStimulus(1, 4'd0, 0, 0, 0);
      applyStimulus(0, 4'd0, 0, 1, 0);
      cycle(20);
      checkTime("at_045", 12'h045);
      cycle(2);
      door_closed = 1'b0;
      cycle(1);
      checkOutput("door_open_running", 16'(running), 16'd0);
      checkOutput("door_open_mag", 16'(mag_on), 16'd0);
      cycle(8);
      checkTime("door_open_hold", 12'h045);
      door_closed = 1'b1;
      applyStimulus(0, 4'd0, 0, 1, 0);
      checkOutput("resume_running", 16'(running), 16'd1);
      checkOutput("resume_phase_kept", 16'(mag_on), 16'd0);
      cycle(4);
      checkTime("resume_tick_044", 12'h044);
      cycle(16);
      checkTime("at_040", 12'h040);
      checkOutput("phase_wrap_mag", 16'(mag_on), 16'd1);
      door_closed = 1'b0;
      cycle(1);
      checkOutput("door_mag_falls", 16'(mag_on), 16'd0);
      checkTime("door_hold_040", 12'h040);
      door_closed = 1'b1;
      applyStimulus(0, 4'd0, 0, 0, 1);
      checkTime("pause_to_idle", 12'h000);
      checkOutput("pause_power_kept", 16'(power_level), 16'd5);

      // Rejected starts
      $display("[TB] rejected starts");
      applyStimulus(0, 4'd0, 0, 0, 1);
      checkOutput("idle_stop_power", 16'(power_level), 16'd10);
      applyStimulus(0, 4'd0, 0, 1, 0);
      checkOutput("reject_zero_time", 16'(running), 16'd0);
      applyStimulus(1, 4'd0, 0, 0, 0);
      applyStimulus(1, 4'd7, 0, 0, 0);
      applyStimulus(1, 4'd5, 0, 0, 0);
      checkTime("entry_075", 12'h075);
      applyStimulus(0, 4'd0, 0, 1, 0);
      checkOutput("reject_tens_7", 16'(running), 16'd0);
      applyStimulus(1, 4'd12, 0, 0, 0);
      checkTime("digit_12_ignored", 12'h075);
      applyStimulus(0, 4'd0, 0, 0, 1);
      applyStimulus(1, 4'd3, 0, 0, 0);
      door_closed = 1'b0;
      applyStimulus(0, 4'd0, 0, 1, 0);
      checkOutput("reject_door_open", 16'(running), 16'd0);
      door_closed = 1'b1;

      // Priority
      $display("[TB] priority");
      applyStimulus(0, 4'd0, 0, 1, 1);
      checkOutput("stop_beats_start", 16'(running), 16'd0);
      checkTime("stop_beats_start_time", 12'h000);
      applyStimulus(1, 4'd2, 1, 0, 0);
      checkTime("key_and_power_time", 12'h002);
      checkOutput("key_and_power_level", 16'(power_level), 16'd9);
      applyStimulus(0, 4'd0, 0, 1, 0);
      cycle(7);
      checkOutput("short_cook_running", 16'(running), 16'd1);
      cycle(1);
      checkOutput("short_done", 16'(done_beep), 16'd1);
      applyStimulus(1, 4'd4, 0, 0, 0);
      checkOutput("key_exits_done", 16'(done_beep), 16'd0);
      checkTime("key_exit_time", 12'h000);
      checkOutput("key_exit_power", 16'(power_level), 16'd10);
      applyStimulus(1, 4'd9, 1, 0, 0);
      applyStimulus(0, 4'd0, 0, 1, 0);
      cycle(6);
      clear = 1'b1;
      cycle(1);
      clear = 1'b0;
      checkTime("clear_time", 12'h000);
      checkOutput("clear_power", 16'(power_level), 16'd10);
      checkOutput("clear_flags", 16'({mag_on, running, done_beep}), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/microwave_cook_ctrl.md
# microwave_cook_ctrl

Parametrised cooking controller: the next-generation core of the microwave design. It takes keypad digit entry into a BCD M:SS register, counts it down at one second per `TICKS_PER_SEC` clocks, and duty-cycles the magnetron according to a selectable power level. It also pauses and resumes on stop or door-open, and drives a timed completion beep. It sits between the keypad front end and the seven-segment decoder, replacing the separate magnetron-control/encoder/timer trio with one clocked block.

## Interface
- `TICKS_PER_SEC`, default 100: clock cycles per second tick; must be ≥ 2.
- `BEEP_SECS`, default 3: seconds `done_beep` stays high after a cook completes; must be ≥ 1.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe; `key_digit` is valid.
- `key_digit`  in  4  BCD digit 0–9; values 10–15 are ignored.
- `power_key`  in  1  one-cycle strobe; steps the power level.
- `start`  in  1  one-cycle strobe.
- `stop`  in  1  one-cycle strobe.
- `door_closed`  in  1  level; 1 means the door is closed.
- `sec_ones`  out  4  BCD seconds ones.
- `sec_tens`  out  4  BCD seconds tens.
- `mins`  out  4  BCD minutes.
- `power_level`  out  4  power level, 1–10.
- `mag_on`  out  1  magnetron enable.
- `running`  out  1  high in COOK.
- `done_beep`  out  1  high in DONE.

## Operation
- **States:** IDLE, COOK, PAUSE, DONE. All outputs are registered.
- **Reset (`clear`=1):** state=IDLE, time=0:00, `power_level`=10. `mag_on`, `running` and `done_beep` are 0. The prescaler, phase counter and beep counter are 0.
- **IDLE, digit entry:** a `key_valid` with a digit ≤ 9 shifts the time left: `mins`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←digit. The old `mins` is discarded. Digits ≥ 10 leave the time unchanged.
- **IDLE, power step:** `power_key` steps the level 10→9→…→1→10.
- **IDLE, stop:** `stop` zeroes the time and sets `power_level`=10.
- **IDLE, start:** `start` moves to COOK only when all of the following hold:
  - `door_closed`=1;
  - time ≠ 0:00;
  - `sec_tens` ≤ 5.
  
  Otherwise `start` is ignored. On entry to COOK the prescaler and phase are both set to 0.
- **COOK, second tick:** a tick occurs when the prescaler equals `TICKS_PER_SEC`−1; the prescaler then wraps to 0. Each tick does three things:
  - decrements the time as BCD M:SS (x:00 → (x−1):59; `sec_ones` 0 → 9 with borrow from `sec_tens`);
  - advances phase 0..9, wrapping to 0;
  - if the new time is 0:00, moves to DONE.
- **COOK, magnetron duty:** `mag_on` = (state==COOK) && `door_closed` && (phase < `power_level`). The result is an on-time of `power_level` seconds per 10-second window.
- **COOK, interruptions:** `stop`, or `door_closed`=0, moves to PAUSE. Time and phase are held.
- **PAUSE:**
  - `start` with `door_closed`=1 resumes COOK; the prescaler resets to 0 and the phase is kept.
  - `stop` goes to IDLE and zeroes the time; `power_level` is kept.
  - Keypad and power inputs are ignored.
- **DONE:** `done_beep`=1, time stays at 0:00. It returns to IDLE after `BEEP_SECS` ticks, or immediately on `stop` or `key_valid`. On leaving DONE, `power_level` resets to 10.
- **Ignored inputs:** keypad and power inputs are ignored in COOK and DONE.
- **Simultaneous events:**
  - `clear` beats everything.
  - `stop` beats `start` in the same cycle.
  - A door-open in the same cycle as a tick: the tick's decrement is applied, then the state moves to PAUSE. If that decrement reaches 0:00, DONE wins.
  - `key_valid` and `power_key` in the same IDLE cycle are both applied.

## Timing
- Input strobe to registered output: one cycle of latency.
- `running` and `mag_on` rise in the cycle after the accepted `start` (subject to `door_closed` and phase).
- The first decrement occurs `TICKS_PER_SEC` cycles after COOK entry.
- `mag_on` falls in the cycle after the door opens. It falls on the same edge that loads 0:00, with no extra cycle.
- A cook of N seconds stays in COOK for exactly N×`TICKS_PER_SEC` cycles when uninterrupted.
- `done_beep` is high for exactly `BEEP_SECS`×`TICKS_PER_SEC` cycles when uninterrupted.

## Test plan
- **Entry and short cook:** bench `TICKS_PER_SEC`=4. After reset, key 1,3,0 then `start` with the door closed → display 1:30, `running`=1. After 4 cycles the display is 1:29. At 1:00 the next tick gives 0:59.
- **Power duty:** set `power_level`=3 (press `power_key` 7 times), cook 0:20 → `mag_on` high for ticks 0–2 and low for ticks 3–9 of each window. Total on-time is 6×`TICKS_PER_SEC` cycles.
- **Pause and resume:** open the door at 0:45 → PAUSE, `mag_on`=0 next cycle, time holds. Close the door and `start` → resumes from 0:45 with the phase preserved. A second `stop` in PAUSE → IDLE, time 0:00.
- **Completion:** cook 0:02 → DONE at 0:00, `done_beep` high for 3×`TICKS_PER_SEC` cycles, then IDLE with `power_level`=10.
- **Rejected starts:** `start` with the door open, with 0:00, or with entry 0,7,5 (`sec_tens`=7) → remains IDLE. Digit 12 leaves the time unchanged.
- **Priority:** `start` and `stop` together in IDLE → time cleared, no COOK. `clear` asserted mid-COOK → all outputs return to their reset values on the next edge.
